// File: rtl/gpu_pkg.sv
// Shared GPU constants: GP0 opcode, VRAM geometry defaults, parameter field
// positions and the VRAM read-back FSM state type.
package gpu_pkg;

  localparam logic [7:0] GP0_B_VRAM2CPU = 8'hC0;

  localparam int VRAM_W_DEF = 1024;
  localparam int VRAM_H_DEF = 512;

  localparam int X_LSB = 0;
  localparam int X_MSB = 9;
  localparam int Y_LSB = 16;
  localparam int Y_MSB = 24;
  localparam int W_LSB = 0;
  localparam int W_MSB = 9;
  localparam int H_LSB = 16;
  localparam int H_MSB = 24;

  typedef enum logic [1:0] {
    IDLE,
    RD_LO,
    RD_HI,
    LAST
  } rb_state_t;

endpackage

// File: rtl/fifo_16x32.sv
// Word FIFO storage for the read-back path. It has no full/empty logic of its own:
// the owner tracks occupancy and never pushes into a full FIFO or pops an empty one.
module fifo_16x32 #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage array is not reset; the reader never looks at an unwritten slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/gpu_vram_readback.sv
// GP0 C0h VRAM-to-CPU copy: scans a rectangle of VRAM halfwords and packs them
// in pairs into a word FIFO that the GPUREAD port drains.
module gpu_vram_readback
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int VRAM_W     = VRAM_W_DEF,
  parameter int VRAM_H     = VRAM_H_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_rst,
  input  logic        start,
  input  logic [31:0] xy_pos,
  input  logic [31:0] wh_size,
  output logic        busy,
  output logic        done,
  output logic        vram_req,
  output logic [19:0] vram_addr,
  input  logic        vram_gnt,
  input  logic [15:0] vram_rdata,
  input  logic        gpuread_re,
  output logic [31:0] gpuread_data,
  output logic        img_ready
);

  localparam int               OW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0]       X_MASK    = 10'(VRAM_W - 1);
  localparam logic [8:0]       Y_MASK    = 9'(VRAM_H - 1);
  localparam logic [OW-1:0]    OCC_LIMIT = OW'(FIFO_DEPTH - 2);

  rb_state_t     state, next_state;
  logic [9:0]    x0, cur_x, col, w_m1;
  logic [8:0]    cur_y, row, h_m1;
  logic [15:0]   lo_q;
  logic [OW-1:0] occ;
  logic [31:0]   last_word, fifo_head, push_data;
  logic          phase, rvalid_q, last_q;
  logic          req_q, req_d, done_q, done_d;
  logic          grant, is_last, space_ok, push, pop;
  logic          unused_bits;

  assign unused_bits = ^{xy_pos[31:25], xy_pos[15:10], wh_size[31:25], wh_size[15:10]};

  assign grant     = req_q & vram_gnt;
  assign is_last   = (col == w_m1) && (row == h_m1);
  assign space_ok  = (occ <= OCC_LIMIT);
  assign push      = rvalid_q && (phase || last_q) && !soft_rst;
  assign push_data = phase ? {vram_rdata, lo_q} : {16'h0000, vram_rdata};
  assign pop       = gpuread_re && (occ != '0) && !soft_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      req_q  <= req_d;
      done_q <= done_d;
    end
  end

  // A low-halfword request is only raised with room for the word already in
  // flight plus this one; once raised it is held until granted.
  always_comb begin
    next_state = state;
    req_d      = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE:  if (start) next_state = RD_LO;
      RD_LO: if (grant) next_state = is_last ? LAST : RD_HI;
      RD_HI: if (grant) next_state = is_last ? LAST : RD_LO;
      LAST: begin
        if (push) begin
          next_state = IDLE;
          done_d     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (soft_rst) begin
      next_state = IDLE;
      done_d     = 1'b0;
    end
    if (next_state == RD_HI) req_d = 1'b1;
    else if (next_state == RD_LO) req_d = (state == RD_LO && req_q && !vram_gnt) || space_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      last_q    <= 1'b0;
      phase     <= 1'b0;
      lo_q      <= '0;
      occ       <= '0;
      last_word <= '0;
    end else begin
      rvalid_q <= grant && !soft_rst;
      last_q   <= grant && is_last;
      if (soft_rst) begin
        phase <= 1'b0;
      end else if (rvalid_q) begin
        if (!phase) lo_q <= vram_rdata;
        phase <= !phase && !last_q;
      end
      occ <= soft_rst ? '0 : occ + OW'(push) - OW'(pop);
      if (pop) last_word <= fifo_head;
    end
  end

  // Scan position: x wraps within a row, y wraps across rows, independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0    <= '0;
      cur_x <= '0;
      cur_y <= '0;
      col   <= '0;
      row   <= '0;
      w_m1  <= '0;
      h_m1  <= '0;
    end else if (state == IDLE && start && !soft_rst) begin
      x0    <= xy_pos[X_MSB:X_LSB] & X_MASK;
      cur_x <= xy_pos[X_MSB:X_LSB] & X_MASK;
      cur_y <= xy_pos[Y_MSB:Y_LSB] & Y_MASK;
      col   <= '0;
      row   <= '0;
      w_m1  <= wh_size[W_MSB:W_LSB] - 10'd1;
      h_m1  <= wh_size[H_MSB:H_LSB] - 9'd1;
    end else if (grant && !is_last) begin
      if (col == w_m1) begin
        col   <= '0;
        row   <= row + 9'd1;
        cur_x <= x0;
        cur_y <= (cur_y + 9'd1) & Y_MASK;
      end else begin
        col   <= col + 10'd1;
        cur_x <= (cur_x + 10'd1) & X_MASK;
      end
    end
  end

  fifo_16x32 #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(soft_rst),
    .push (push),
    .wdata(push_data),
    .pop  (pop),
    .rdata(fifo_head)
  );

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign vram_req     = req_q;
  assign vram_addr    = {cur_y, cur_x, 1'b0};
  assign img_ready    = (occ != '0);
  assign gpuread_data = img_ready ? fifo_head : last_word;

endmodule

// File: tb/tb_gpu_vram_readback.sv
// Bench for gpu_vram_readback: VRAM model returns address/2, a scoreboard queues
// expected addresses and words per transfer and checks them as the DUT produces them.
module tb_gpu_vram_readback;

  logic        clk = 1'b0;
  logic        rst, soft_rst, start;
  logic [31:0] xy_pos, wh_size;
  logic        busy, done, vram_req, vram_gnt, gpuread_re, img_ready;
  logic [19:0] vram_addr;
  logic [15:0] vram_rdata;
  logic [31:0] gpuread_data;

  gpu_vram_readback dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst    (soft_rst),
    .start       (start),
    .xy_pos      (xy_pos),
    .wh_size     (wh_size),
    .busy        (busy),
    .done        (done),
    .vram_req    (vram_req),
    .vram_addr   (vram_addr),
    .vram_gnt    (vram_gnt),
    .vram_rdata  (vram_rdata),
    .gpuread_re  (gpuread_re),
    .gpuread_data(gpuread_data),
    .img_ready   (img_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] xy;
    logic [31:0] wh;
    bit          rnd;
    bit          inject;
    int          nwords;
    logic [31:0] first;
    logic [31:0] last;
    int          ready_at;
    int          done_at;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  logic [19:0] addr_q[$];
  int          n_checks, n_pass;
  int          cyc, ready_cyc, done_cyc, done_cnt, pop_cnt;
  bit          gnt_random, pop_en, pend_gnt;
  logic [19:0] pend_addr;
  logic [31:0] first_popped, last_popped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [15:0] hw_of(input logic [19:0] a);
    return a[16:1];
  endfunction

  // Expected address sequence and packed words for one rectangle.
  task automatic load_model(input logic [31:0] xy, input logic [31:0] wh);
    int w, h, n, lim, x, y;
    logic [19:0] a;
    logic [15:0] lo;
    lo = '0;
    w = ((int'(wh[9:0]) - 1) & 32'h3FF) + 1;
    h = ((int'(wh[24:16]) - 1) & 32'h1FF) + 1;
    n = w * h;
    lim = (n > 4096) ? 4096 : n;
    for (int k = 0; k < lim; k++) begin
      x = (int'(xy[9:0]) + k % w) % 1024;
      y = (int'(xy[24:16]) + k / w) % 512;
      a = {y[8:0], x[9:0], 1'b0};
      addr_q.push_back(a);
      if (k % 2 == 0) begin
        lo = hw_of(a);
        if (k == n - 1) exp_q.push_back({16'h0000, lo});
      end else begin
        exp_q.push_back({hw_of(a), lo});
      end
    end
  endtask

  // One cycle: VRAM responder, address scoreboard, done tracking, optional pop.
  task automatic step();
    @(negedge clk);
    cyc++;
    vram_rdata = pend_gnt ? hw_of(pend_addr) : 16'h0000;
    vram_gnt   = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
    pend_gnt   = vram_req && vram_gnt;
    pend_addr  = vram_addr;
    if (pend_gnt && addr_q.size() > 0) check("vram_addr", 32'(vram_addr), 32'(addr_q.pop_front()));
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      check("busy_at_done", 32'(busy), 32'd0);
    end
    if (img_ready && ready_cyc < 0) ready_cyc = cyc;
    gpuread_re = 1'b0;
    if (pop_en && img_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL extra_word: got 0x%08h, expected no word", gpuread_data);
      end else begin
        check("word", gpuread_data, exp_q.pop_front());
      end
      if (pop_cnt == 0) first_popped = gpuread_data;
      last_popped = gpuread_data;
      pop_cnt++;
      gpuread_re = 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] xy, input logic [31:0] wh);
    step();
    xy_pos    = xy;
    wh_size   = wh;
    start     = 1'b1;
    cyc       = 0;
    ready_cyc = -1;
    done_cyc  = -1;
    done_cnt  = 0;
    pop_cnt   = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(done_cnt > 0 && exp_q.size() == 0 && !img_ready)) begin
      if (n >= budget) begin
        n_checks++;
        $display("[TB] FAIL timeout: got %0d done pulses, %0d words left, expected completion", done_cnt, exp_q.size());
        break;
      end
      step();
      n++;
    end
    repeat (4) step();
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_q.delete();
    addr_q.delete();
    pop_en     = 1'b1;
    gnt_random = v.rnd;
    load_model(v.xy, v.wh);
    pulse_start(v.xy, v.wh);
    check("busy_rise", 32'(busy), 32'd1);
    if (v.inject) begin
      repeat (4) step();
      xy_pos  = 32'h0000_0000;
      wh_size = 32'h0001_0001;
      start   = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done(6000);
  endtask

  task automatic checkOutput(input vec_t v);
    check("word_count", 32'(pop_cnt), 32'(v.nwords));
    check("first_word", first_popped, v.first);
    check("last_word", last_popped, v.last);
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (v.ready_at >= 0) check("img_ready_cycle", 32'(ready_cyc), 32'(v.ready_at));
    if (v.done_at >= 0) check("done_cycle", 32'(done_cyc), 32'(v.done_at));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_vram_req"}, 32'(vram_req), 32'd0);
    check({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
    check({tag, "_img_ready"}, 32'(img_ready), 32'd0);
    check({tag, "_gpuread_data"}, gpuread_data, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; soft_rst = 1'b0; start = 1'b0; gpuread_re = 1'b0;
    xy_pos = '0; wh_size = '0; vram_gnt = 1'b0; vram_rdata = '0;
    gnt_random = 1'b0; pop_en = 1'b0; pend_gnt = 1'b0; pend_addr = '0;
    cyc = 0; ready_cyc = -1; done_cyc = -1; done_cnt = 0; pop_cnt = 0;
    first_popped = '0; last_popped = '0;

    vecs[0] = '{32'h0000_0000, 32'h0002_0002, 1'b0, 1'b0, 2,   32'h0001_0000, 32'h0401_0400, 4, 6};
    vecs[1] = '{32'h01FF_03FF, 32'h0001_0003, 1'b0, 1'b0, 2,   32'hFC00_FFFF, 32'h0000_FC01, 4, 5};
    vecs[2] = '{32'h0014_000A, 32'h0003_0005, 1'b1, 1'b1, 8,   32'h500B_500A, 32'h0000_580E, -1, -1};
    vecs[3] = '{32'h0005_0005, 32'h0001_0001, 1'b0, 1'b0, 1,   32'h0000_1405, 32'h0000_1405, 3, 3};
    vecs[4] = '{32'h0003_0000, 32'h0001_0000, 1'b0, 1'b0, 512, 32'h0C01_0C00, 32'h0FFF_0FFE, 4, -1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0002, 1'b0, 1'b0, 512, 32'h0001_0000, 32'hFC01_FC00, 4, -1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d: xy=0x%08h wh=0x%08h", i, vecs[i].xy, vecs[i].wh);
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Backpressure: 64x1 without pops fills exactly 16 words, then drains in order.
    $display("[TB] backpressure 64x1");
    exp_q.delete(); addr_q.delete();
    pop_en = 1'b0; gnt_random = 1'b0;
    load_model(32'h0000_0000, 32'h0001_0040);
    pulse_start(32'h0000_0000, 32'h0001_0040);
    repeat (60) step();
    check("bp_halfwords_left", 32'(addr_q.size()), 32'd32);
    check("bp_vram_req", 32'(vram_req), 32'd0);
    check("bp_img_ready", 32'(img_ready), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    pop_en = 1'b1;
    wait_done(1000);
    check("bp_word_count", 32'(pop_cnt), 32'd32);
    check("bp_last_word", last_popped, 32'h003F_003E);
    pop_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      gpuread_re = 1'b1;
      @(negedge clk);
      check("empty_pop_data", gpuread_data, 32'h003F_003E);
      check("empty_pop_ready", 32'(img_ready), 32'd0);
    end
    gpuread_re = 1'b0;

    // Maximum size transfer aborted by soft_rst after 100 words.
    $display("[TB] wh=0 abort");
    exp_q.delete(); addr_q.delete();
    pop_en = 1'b1; gnt_random = 1'b0;
    load_model(32'h0000_0000, 32'h0000_0000);
    pulse_start(32'h0000_0000, 32'h0000_0000);
    begin
      int n;
      n = 0;
      while (pop_cnt < 100 && n < 2000) begin
        step();
        n++;
      end
    end
    check("abort_reached_100", 32'(pop_cnt >= 100), 32'd1);
    pop_en = 1'b0;
    step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    exp_q.delete(); addr_q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_img_ready", 32'(img_ready), 32'd0);
    check("abort_last_word", gpuread_data, last_popped);
    repeat (20) step();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle_req", 32'(vram_req), 32'd0);
    check("abort_stays_empty", 32'(img_ready), 32'd0);

    // Async reset between clock edges, then a fresh 2x2 transfer.
    $display("[TB] async reset");
    exp_q.delete(); addr_q.delete();
    pop_en = 1'b1;
    load_model(32'h0000_0000, 32'h0002_0008);
    pulse_start(32'h0000_0000, 32'h0002_0008);
    repeat (8) step();
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    exp_q.delete(); addr_q.delete();
    pop_en = 1'b0; pend_gnt = 1'b0; gpuread_re = 1'b0;
    step();
    rst = 1'b0;
    applyStimulus(vecs[0]);
    checkOutput(vecs[0]);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_vram_readback.md
# gpu_vram_readback

Returns VRAM contents to the CPU/DMA side through the GPUREAD port. Executes the GP0 C0h (VRAM-to-CPU) rectangle copy: reads 16-bit halfwords over the VRAM bus, packs pairs into 32-bit words and buffers them in a FIFO that the main-bus side pops. It is the read-back counterpart of the GP0 command-FIFO/write path and sits beside the GPU command decoder, sharing the VRAM arbiter.

## Interface
- `FIFO_DEPTH`, 16: read-back FIFO depth in 32-bit words (power of 2, ≥4).
- `VRAM_W`, 1024: VRAM width in halfwords (power of 2).
- `VRAM_H`, 512: VRAM height in lines (power of 2).

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `soft_rst`  in  1  — GP1 reset/clear-FIFO pulse: flushes the FIFO and aborts the transfer.
- `start`  in  1  — one-cycle pulse from the decoder: C0h parameters are valid.
- `xy_pos`  in  32  — source position: x=[9:0], y=[24:16].
- `wh_size`  in  32  — size: w=[9:0], h=[24:16].
- `busy`  out  1  — transfer in progress.
- `done`  out  1  — one-cycle pulse after the last word is pushed.
- `vram_req`  out  1  — halfword read request.
- `vram_addr`  out  20  — byte address {y[8:0], x[9:0], 1'b0}.
- `vram_gnt`  in  1  — request accepted this cycle.
- `vram_rdata`  in  16  — read data, valid the cycle after `vram_gnt`.
- `gpuread_re`  in  1  — GPUREAD pop strobe from the bus/DMA.
- `gpuread_data`  out  32  — FIFO head if non-empty, else the last popped word.
- `img_ready`  out  1  — FIFO non-empty (GPUSTAT bit 27; also the DMA request).

## Operation
- Size decode: w = ((wh[9:0]−1) & 0x3FF)+1 and h = ((wh[24:16]−1) & 0x1FF)+1, so a field of 0 means the maximum. Total halfwords N = w·h (20 bits); number of words = ceil(N/2).
- Scan order is row-major. Address x = (x0+col) mod VRAM_W and y = (y0+row) mod VRAM_H; both wrap independently.
- Packing: the first halfword goes to [15:0] and the second to [31:16]. If N is odd, the final word has [31:16]=0.
- FSM:
  - IDLE: on `start`, latch the parameters, go to RD_LO.
  - RD_LO: issue a request only when occupancy ≤ FIFO_DEPTH−2; otherwise stall with `vram_req`=0. On gnt: go to RD_HI, or to LAST if this was the final odd halfword.
  - RD_HI: on gnt: go to RD_LO, or to LAST if this was the final halfword.
  - LAST: wait for the final capture/push, pulse `done`, go to IDLE.
- Capture: `rvalid_q` is `vram_gnt` delayed one cycle. On `rvalid_q`, the phase bit selects the lo or hi register. A hi capture (or an odd final lo capture) pushes the word in that cycle.
- The occupancy guard ensures a push never meets a full FIFO.
- Pop: `gpuread_re` while non-empty pops the head and copies it into `last_word`. `gpuread_re` while empty has no effect, and `gpuread_data` holds `last_word`.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- `start` while `busy` is ignored.
- `soft_rst` takes priority over `start` and over a push in the same cycle:
  - effect next cycle: FSM to IDLE, FIFO empty, phase cleared, `busy`=0;
  - no `done` pulse;
  - `last_word` is kept;
  - an `rdata` capture already in flight is discarded.
- Reset values: `busy`=0, `done`=0, `vram_req`=0, `vram_addr`=0, `img_ready`=0, `gpuread_data`=0, `last_word`=0, FSM=IDLE.

## Timing
- Best-case throughput is one word per 2 cycles (gnt every cycle).
- Latency with gnt always high:
  - start at cycle 0;
  - `vram_req` at cycle 1 (RD_LO);
  - lo captured at 2;
  - hi captured and pushed at 3;
  - `img_ready`=1 at 4.
- `busy` rises the cycle after `start`. It falls together with the `done` pulse, the cycle after the last push.
- `gpuread_data` is combinational from the FIFO head/`last_word` and changes the cycle after a pop.
- `vram_addr` and `vram_req` are registered and held stable until gnt.

## Structure
- `gpu_pkg` holds: GP0_B_VRAM2CPU = 'hC0, the VRAM_W/VRAM_H defaults, the FSM state enum (IDLE, RD_LO, RD_HI, LAST), and the x/y/w/h field slice constants.
- Sub-module: reuse `fifo_16x32` for storage. Keep a local occupancy counter ($clog2(FIFO_DEPTH)+1 bits) for the space guard.

## Test plan
- **2×2 at (0,0)**, memory = address/2, gnt always 1 → words 0x0001_0000 then 0x0401_0400; `img_ready` at cycle 4; `done` once.
- **3×1 at (1023,511)** → addresses 0xFFFFE, 0xFF800 and 0xFF802 (x wraps, y stays 511); 2 words, second word has [31:16]=0.
- **wh=0x0000_0000** → 1024×512 size decoded. Abort with `soft_rst` after 100 pushes → FIFO empty, `busy`=0, no `done`.
- **Backpressure:** 64×1 with no pops → exactly 16 words buffered, `vram_req`=0 while full. Then pop steadily → all 32 words in order; `gpuread_re` with FIFO empty returns the last word (repeated).
- **Random gnt** (50%) on 5×3 at (10,20) → 8 words matching the scoreboard; `start` pulsed mid-transfer is ignored.
- **Async `rst`** asserted mid-transfer, between clock edges → all outputs 0 immediately. After release, a new 2×2 start behaves as in the first test.
